vga_sync_gen: RTL
=================

# vga_sync_gen

Timing generator for the VGA display path. It produces the pixel-coordinate and blanking interface consumed by the graphics renderer (pix_x, pix_y, video_on). It also drives the hsync and vsync pins, and emits per-pixel, per-line and per-frame strobes so that position-update logic can advance once per frame. Default timing is 640x480 at 60 Hz, with a 25 MHz pixel rate derived from the 100 MHz system clock.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel; legal range 1..16
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)
- PIPE_DELAY, 0, pixel ticks by which hsync/vsync lag pix_x/pix_y, to match the renderer pipeline; legal range 0..7
- clk  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clk
- p_tick  out  1  one-clk pulse marking a pixel boundary
- pix_x  out  10  current horizontal count, 0..H_TOTAL-1
- pix_y  out  10  current vertical count, 0..V_TOTAL-1
- video_on  out  1  high when pix_x < H_DISPLAY and pix_y < V_DISPLAY
- hsync  out  1  horizontal sync, delayed by PIPE_DELAY
- vsync  out  1  vertical sync, delayed by PIPE_DELAY
- line_start  out  1  one-clk pulse on p_tick when pix_x == 0
- frame_start  out  1  one-clk pulse on p_tick when pix_x == 0 and pix_y == 0

## Operation
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div_cnt == CLK_DIV-1).
  - With CLK_DIV=1, p_tick is held high.
- Horizontal counter h_cnt advances only on p_tick: it increments, and wraps from H_TOTAL-1 to 0.
- Vertical counter v_cnt advances only on a p_tick where h_cnt == H_TOTAL-1: it increments, and wraps from V_TOTAL-1 to 0.
- pix_x = h_cnt and pix_y = v_cnt, driven directly from the registers.
- video_on, line_start and frame_start are combinational from registered state (div_cnt, h_cnt, v_cnt).
- Raw sync levels:
  - hsync_raw is asserted when H_DISPLAY+H_FRONT <= h_cnt <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751).
  - vsync_raw is asserted when V_DISPLAY+V_FRONT <= v_cnt <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491).
- Raw syncs are registered once, after which they pass through a PIPE_DELAY-stage shift register.
  - The shift register advances only on p_tick.
  - Output polarity is set by SYNC_ACTIVE.
- Reset values:
  - div_cnt, h_cnt and v_cnt are 0, so pix_x = 0, pix_y = 0 and video_on = 1.
  - p_tick is 0, unless CLK_DIV = 1.
  - line_start and frame_start are 0.
  - hsync, vsync and every delay stage are at the deasserted level (1 with the defaults).
- Reset mid-frame: counters return to 0 on the next clk and the delay line flushes to deasserted. No partial sync pulse may be emitted after reset.

## Timing
- The first p_tick after reset release occurs in clk cycle CLK_DIV-1, counting the first non-reset cycle as 0. frame_start and line_start fire in that same cycle.
- Counter updates land on the clk edge that ends the p_tick cycle, so pix_x is stable for exactly CLK_DIV clks.
- Registered sync lags its h_cnt/v_cnt condition by 1 pixel when PIPE_DELAY=0. Total lag = PIPE_DELAY+1 pixel periods.
- Line period = H_TOTAL*CLK_DIV clks (3200). Frame period = H_TOTAL*V_TOTAL*CLK_DIV clks (1,680,000).
- hsync is asserted for exactly H_SYNC*CLK_DIV clks (384). vsync is asserted for exactly V_SYNC*H_TOTAL*CLK_DIV clks (6400).

## Test plan
- Reset release, defaults: p_tick first high at cycle 3 and then every 4 clks. frame_start is high together with that first p_tick. pix_x reads 1 at cycle 4.
- Run one line: hsync goes low while pix_x == 657 (registered lag), stays low 384 clks, and returns high while pix_x == 753. line_start pulses are exactly 3200 clks apart.
- Run one full frame: frame_start pulses are 1,680,000 clks apart. Count of p_tick cycles with video_on = 307,200. Exactly 2 lines have vsync low. pix_y wraps 524 -> 0 at the same edge where pix_x wraps 799 -> 0.
- PIPE_DELAY=3: hsync falling edge occurs 3 pixel periods (12 clks) later than in the PIPE_DELAY=0 run. Pulse width is unchanged at 384 clks.
- CLK_DIV=1, SYNC_ACTIVE=1: p_tick is constantly 1. hsync is high for 96 consecutive clks per 800-clk line.
- Assert reset for 1 clk while pix_y=490 and vsync is active: the next cycle shows pix_x=0, pix_y=0, hsync=vsync=1, and the frame restarts with timing identical to the first test.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, h/v position counters, blanking and
// frame/line strobes, plus sync outputs delayed to line up with the renderer pipeline.
module vga_sync_gen #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int CLK_DIV     = 4,
    parameter int SYNC_ACTIVE = 0,
    parameter int PIPE_DELAY  = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic       ACT_LVL  = 1'(SYNC_ACTIVE);

    logic [3:0]            div_cnt;
    logic [9:0]            h_cnt;
    logic [9:0]            v_cnt;
    logic                  h_end;
    logic                  hsync_raw;
    logic                  vsync_raw;
    // Stage 0 is the registered raw sync; stage PIPE_DELAY feeds the pins.
    // Stored as 1 = asserted, polarity applied only at the output.
    logic [PIPE_DELAY:0]   hs_pipe;
    logic [PIPE_DELAY:0]   vs_pipe;

    assign p_tick    = (div_cnt == DIV_LAST);
    assign h_end     = (h_cnt == H_LAST);
    assign hsync_raw = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    assign vsync_raw = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (p_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (p_tick) begin
            if (h_end) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_pipe <= '0;
            vs_pipe <= '0;
        end else if (p_tick) begin
            hs_pipe[0] <= hsync_raw;
            vs_pipe[0] <= vsync_raw;
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                hs_pipe[i] <= hs_pipe[i-1];
                vs_pipe[i] <= vs_pipe[i-1];
            end
        end
    end

    assign pix_x       = h_cnt;
    assign pix_y       = v_cnt;
    assign video_on    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign line_start  = p_tick && (h_cnt == 10'd0);
    assign frame_start = line_start && (v_cnt == 10'd0);
    assign hsync       = ACT_LVL ? hs_pipe[PIPE_DELAY] : ~hs_pipe[PIPE_DELAY];
    assign vsync       = ACT_LVL ? vs_pipe[PIPE_DELAY] : ~vs_pipe[PIPE_DELAY];

endmodule
